mor1kx_divider_marocchino: RTL and testbench
============================================

# mor1kx_divider_marocchino

Parametrised iterative integer divider for the MAROCCHINO execute stage. It replaces the fixed 32-bit, 1-bit-per-cycle divider embedded in the execute ALU with a standalone unit that has:
- configurable operand width and bits retired per clock;
- a start/ready/valid/ack handshake;
- remainder output, signed and unsigned modes, and pipeline flush.

The execute stage instantiates it and feeds the quotient into its result mux and the divide-by-zero flag into its carry/overflow logic.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, operand/result width W; must be divisible by OPTION_DIV_BITS_PER_CLK.
- OPTION_DIV_BITS_PER_CLK, 1, quotient bits S produced per iteration cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush; aborts any operation.
- start_i  in  1  request a new division; accepted when start_i & ready_o.
- signed_i  in  1  1 = signed (l.div), 0 = unsigned (l.divu); sampled on accept.
- dividend_i  in  W  dividend; sampled on accept.
- divisor_i  in  W  divisor; sampled on accept.
- ack_i  in  1  consumer takes the result (driven by padv_wb).
- ready_o  out  1  unit can accept start_i this cycle.
- valid_o  out  1  quotient_o/remainder_o/div_by_zero_o valid.
- quotient_o  out  W  quotient.
- remainder_o  out  W  remainder.
- div_by_zero_o  out  1  divisor was zero.

## Operation
- States: IDLE, ITER, FIX, DONE. Reset, and flush_i from any state, → IDLE next cycle.
- **IDLE:** ready_o=1. On accept:
  - latch absolute values of the operands (two's-complement negate when signed_i and MSB set);
  - neg_q = signed_i & (dividend MSB ^ divisor MSB);
  - neg_r = signed_i & dividend MSB;
  - dbz = (divisor_i==0);
  - load iteration counter with W/S; → ITER.
- **ITER:**
  - Each cycle performs S restoring steps: shift {rem, num} left one bit, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - Counter decrements by 1 per cycle; counter width = clog2(W/S+1).
  - When the counter reaches 1 in this cycle → FIX.
- **FIX:** negate the quotient if neg_q & ~dbz; negate the remainder if neg_r & ~dbz; → DONE.
- **DONE:**
  - valid_o=1 and ready_o=1; outputs held stable.
  - ack_i alone → IDLE.
  - start_i (with or without ack_i) → accepted as a new operation, implicitly acknowledging the old result; → ITER, valid_o drops next cycle.
- **Divide by zero:** quotient_o = all ones, remainder_o = original dividend_i bits, div_by_zero_o = 1.
- **Signed overflow:** 0x80000000 / -1 (W=32) gives quotient 0x80000000, remainder 0, div_by_zero_o = 0. No trap is raised.
- **Rounding:** quotient truncates toward zero; the remainder takes the sign of the dividend.
- **Priority:**
  - flush_i beats start_i and ack_i in the same cycle.
  - start_i outside IDLE/DONE is ignored (ready_o=0).
- **Reset values:** ready_o=1; valid_o=0; quotient_o, remainder_o, div_by_zero_o = 0.

## Timing
- Take the accept cycle as cycle 0:
  - ITER occupies cycles 1..W/S;
  - FIX occupies cycle W/S+1;
  - valid_o rises in cycle W/S+2.
- Latency examples: W=32, S=1 → 34 cycles; S=2 → 18; S=4 → 10.
- Back-to-back: a start accepted in DONE gives the next valid exactly W/S+2 cycles later, with no idle bubble.
- Flush asserted in cycle k: ready_o=1 and valid_o=0 in cycle k+1. No stale valid ever appears.
- Outputs are registered; ready_o is decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: MOR1KX_DIV_EARLY_OUT_EN.
- **Defined:** if the divisor or the dividend is zero at accept, ITER is skipped and the unit goes IDLE → FIX directly, so valid_o rises in cycle 2.
  - Zero dividend: quotient 0, remainder 0.
  - Zero divisor: results as specified under Operation.
- **Undefined:** every operation takes the full W/S+2 latency. Results are bit-identical in both builds; only latency differs.

## Test plan
- Unsigned 100/7, W=32, S=1: start at cycle 0 → valid_o in cycle 34, quotient 14, remainder 2, div_by_zero_o 0.
- Signed -7/2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
- 5/0 unsigned: div_by_zero_o 1, quotient 0xFFFFFFFF, remainder 5.
  - Valid in cycle 2 with MOR1KX_DIV_EARLY_OUT_EN defined, cycle 34 without.
- flush_i at cycle 10 of an operation → ready_o=1 in cycle 11, and valid_o stays 0 for 40 further cycles.
- Back-to-back: start 100/7, then start 9/3 in the first DONE cycle while ack_i=0.
  - First result is held for exactly one valid cycle.
  - Second result (quotient 3, remainder 0) is valid 34 cycles later.
- Repeat the same back-to-back sequence with S=2 (valid cycle 18) and S=4 (valid cycle 10).

Source files
------------

// File: rtl/mor1kx_divider_marocchino.sv
// rtl/mor1kx_divider_marocchino.sv - iterative restoring integer divider for the MAROCCHINO execute stage
//
// Purpose: signed/unsigned W-bit division retiring S quotient bits per clock,
// with start/ready/valid/ack handshake, remainder output and pipeline flush.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   flush_i        abort any operation, return to IDLE
//   start_i        request a division (accepted when start_i & ready_o)
//   signed_i       1 = signed (l.div), 0 = unsigned (l.divu)
//   dividend_i     dividend, sampled on accept
//   divisor_i      divisor, sampled on accept
//   ack_i          consumer takes the result
//   ready_o        unit accepts start_i this cycle
//   valid_o        quotient_o/remainder_o/div_by_zero_o valid
//   quotient_o     quotient (truncated toward zero)
//   remainder_o    remainder (sign of dividend)
//   div_by_zero_o  divisor was zero
//
// Configuration macro: MOR1KX_DIV_EARLY_OUT_EN - when defined, a zero dividend
// or zero divisor skips ITER and goes straight to FIX.

module mor1kx_divider_marocchino #(
  parameter int OPTION_OPERAND_WIDTH    = 32,
  parameter int OPTION_DIV_BITS_PER_CLK = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic                            start_i,
  input  logic                            signed_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dividend_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] divisor_i,
  input  logic                            ack_i,
  output logic                            ready_o,
  output logic                            valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] quotient_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] remainder_o,
  output logic                            div_by_zero_o
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int S     = OPTION_DIV_BITS_PER_CLK;
  localparam int NITER = W / S;
  localparam int CW    = $clog2(NITER + 1);

  localparam logic [W-1:0]  ONE      = W'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NITER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t        state_q, state_d, first_state;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q, num_q, dvs_q, dvd_raw_q;
  logic          neg_q_q, neg_r_q, dbz_q;
  logic [W-1:0]  quotient_q, remainder_q;
  logic          dbz_out_q;

  logic          accept;
  logic          dvd_neg, dvs_neg;
  logic [W-1:0]  dvd_abs, dvs_abs;
  logic [W-1:0]  iter_rem, iter_num;
  logic [W:0]    shifted, trial;
  logic [W-1:0]  q_fix, r_fix;

  assign ready_o       = (state_q == IDLE) || (state_q == DONE);
  assign valid_o       = (state_q == DONE);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_out_q;

  // Flush wins over a start in the same cycle.
  assign accept = start_i & ready_o & ~flush_i;

  assign dvd_neg = signed_i & dividend_i[W-1];
  assign dvs_neg = signed_i & divisor_i[W-1];
  assign dvd_abs = dvd_neg ? (~dividend_i + ONE) : dividend_i;
  assign dvs_abs = dvs_neg ? (~divisor_i + ONE) : divisor_i;

`ifdef MOR1KX_DIV_EARLY_OUT_EN
  // With a zero operand the loaded registers already hold the final
  // magnitudes (or are overridden for divide-by-zero), so ITER is skipped.
  assign first_state = ((dividend_i == '0) || (divisor_i == '0)) ? FIX : ITER;
`else
  assign first_state = ITER;
`endif

  // S restoring steps per cycle. The quotient bits shift into num_q as the
  // dividend bits shift out of it into the partial remainder.
  always_comb begin
    iter_rem = rem_q;
    iter_num = num_q;
    shifted  = '0;
    trial    = '0;
    for (int k = 0; k < S; k++) begin
      shifted = {iter_rem, iter_num[W-1]};
      trial   = shifted - {1'b0, dvs_q};
      iter_rem = trial[W] ? shifted[W-1:0] : trial[W-1:0];
      iter_num = {iter_num[W-2:0], ~trial[W]};
    end
  end

  // Sign fix-up; divide-by-zero bypasses it and reports the raw dividend.
  always_comb begin
    q_fix = (neg_q_q & ~dbz_q) ? (~num_q + ONE) : num_q;
    r_fix = (neg_r_q & ~dbz_q) ? (~rem_q + ONE) : rem_q;
    if (dbz_q) begin
      q_fix = '1;
      r_fix = dvd_raw_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = first_state;
      ITER:    if (cnt_q == CNT_ONE) state_d = FIX;
      FIX:     state_d = DONE;
      DONE: begin
        if (accept)     state_d = first_state;
        else if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      num_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rem_q     <= '0;
        num_q     <= dvd_abs;
        dvs_q     <= dvs_abs;
        dvd_raw_q <= dividend_i;
        neg_q_q   <= dvd_neg ^ dvs_neg;
        neg_r_q   <= dvd_neg;
        dbz_q     <= (divisor_i == '0);
        cnt_q     <= CNT_LOAD;
      end else if (state_q == ITER) begin
        rem_q <= iter_rem;
        num_q <= iter_num;
        cnt_q <= cnt_q - CNT_ONE;
      end
      if (state_q == FIX) begin
        quotient_q  <= q_fix;
        remainder_q <= r_fix;
        dbz_out_q   <= dbz_q;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_divider_marocchino.sv
// tb/tb_mor1kx_divider_marocchino.sv - directed self-checking bench for mor1kx_divider_marocchino

module tb_mor1kx_divider_marocchino;

`ifdef MOR1KX_DIV_EARLY_OUT_EN
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_ZERO = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, start, sgn, ack;
  logic [31:0] dvd, dvs;
  int          sel;

  logic        rdy1, vld1, z1, rdy2, vld2, z2, rdy4, vld4, z4;
  logic [31:0] q1, r1, q2, r2, q4, r4;
  logic        s_rdy, s_vld, s_z;
  logic [31:0] s_q, s_r;
  logic        st1, st2, st4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);
  assign st4 = start && (sel == 4);

  mor1kx_divider_marocchino #(.OPTION_OPERAND_WIDTH(32), .OPTION_DIV_BITS_PER_CLK(1)) u_s1 (
    .clk(clk), .rst(rst), .flush_i(flush), .start_i(st1), .signed_i(sgn),
    .dividend_i(dvd), .divisor_i(dvs), .ack_i(ack), .ready_o(rdy1), .valid_o(vld1),
    .quotient_o(q1), .remainder_o(r1), .div_by_zero_o(z1));

  mor1kx_divider_marocchino #(.OPTION_OPERAND_WIDTH(32), .OPTION_DIV_BITS_PER_CLK(2)) u_s2 (
    .clk(clk), .rst(rst), .flush_i(flush), .start_i(st2), .signed_i(sgn),
    .dividend_i(dvd), .divisor_i(dvs), .ack_i(ack), .ready_o(rdy2), .valid_o(vld2),
    .quotient_o(q2), .remainder_o(r2), .div_by_zero_o(z2));

  mor1kx_divider_marocchino #(.OPTION_OPERAND_WIDTH(32), .OPTION_DIV_BITS_PER_CLK(4)) u_s4 (
    .clk(clk), .rst(rst), .flush_i(flush), .start_i(st4), .signed_i(sgn),
    .dividend_i(dvd), .divisor_i(dvs), .ack_i(ack), .ready_o(rdy4), .valid_o(vld4),
    .quotient_o(q4), .remainder_o(r4), .div_by_zero_o(z4));

  always_comb begin
    s_rdy = rdy1; s_vld = vld1; s_q = q1; s_r = r1; s_z = z1;
    if (sel == 2) begin
      s_rdy = rdy2; s_vld = vld2; s_q = q2; s_r = r2; s_z = z2;
    end else if (sel == 4) begin
      s_rdy = rdy4; s_vld = vld4; s_q = q4; s_r = r4; s_z = z4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 of the accept cycle (cycle 0); returns at posedge+1
  // of the first valid cycle, or at the cycle budget.
  task automatic start_and_wait(output int lat, output logic v_at1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    v_at1 = s_vld;
    while (!s_vld && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check({tag, "_vld_after_ack"}, 32'(s_vld), 32'd0);
    check({tag, "_rdy_after_ack"}, 32'(s_rdy), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                       input logic ez, input int hold);
    int   lat;
    logic v1;
    sgn = s; dvd = a; dvs = b;
    start_and_wait(lat, v1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_quot"}, s_q, eq);
    check({tag, "_rem"}, s_r, er);
    check({tag, "_dbz"}, 32'(s_z), 32'(ez));
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check({tag, "_held_vld"}, 32'(s_vld), 32'd1);
      check({tag, "_held_quot"}, s_q, eq);
    end
    do_ack(tag);
  endtask

  task automatic back_to_back(input string tag, input int which, input int exp_lat);
    int   lat;
    logic v1;
    sel = which; sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
    start_and_wait(lat, v1);
    check({tag, "_first_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_first_quot"}, s_q, 32'd14);
    check({tag, "_first_rem"}, s_r, 32'd2);
    dvd = 32'd9; dvs = 32'd3; ack = 1'b0;
    start_and_wait(lat, v1);
    check({tag, "_one_valid_cycle"}, 32'(v1), 32'd0);
    check({tag, "_second_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_second_quot"}, s_q, 32'd3);
    check({tag, "_second_rem"}, s_r, 32'd0);
    do_ack(tag);
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; start = 1'b0; sgn = 1'b0; ack = 1'b0;
    dvd = '0; dvs = '0; sel = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_ready_s1", 32'(rdy1), 32'd1);
    check("reset_ready_s4", 32'(rdy4), 32'd1);
    check("reset_valid", 32'(vld1), 32'd0);
    check("reset_quot", q1, 32'd0);
    check("reset_rem", r1, 32'd0);
    check("reset_dbz", 32'(z1), 32'd0);

    do_op("u100_7",   1'b0, 32'd100,        32'd7,          34,       32'd14,         32'd2,          1'b0, 2);
    do_op("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          34,       32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 0);
    do_op("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   34,       32'hFFFFFFFD,   32'd1,          1'b0, 0);
    do_op("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   34,       32'h80000000,   32'd0,          1'b0, 0);
    do_op("u_max_16", 1'b0, 32'hFFFFFFFF,   32'd16,         34,       32'h0FFFFFFF,   32'd15,         1'b0, 0);
    do_op("u5_0",     1'b0, 32'd5,          32'd0,          LAT_ZERO, 32'hFFFFFFFF,   32'd5,          1'b1, 0);
    do_op("s-5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          LAT_ZERO, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 0);
    do_op("s0_-5",    1'b1, 32'd0,          32'hFFFFFFFB,   LAT_ZERO, 32'd0,          32'd0,          1'b0, 0);

    // Flush in cycle 10 of an operation.
    sgn = 1'b0; dvd = 32'd100; dvs = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush_busy_ready", 32'(s_rdy), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", 32'(s_rdy), 32'd1);
    check("flush_valid", 32'(s_vld), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s_vld) seen++;
    end
    check("flush_no_stale_valid", 32'(seen), 32'd0);
    do_op("after_flush", 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0, 0);

    back_to_back("b2b_s1", 1, 34);
    back_to_back("b2b_s2", 2, 18);
    back_to_back("b2b_s4", 4, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
